// File: rtl/rect_bounce_ctl_pkg.sv
// Shared types and geometry constants for the bouncing-rectangle position controller.
package rect_bounce_ctl_pkg;

  localparam int unsigned RECT_LENGTH = 64;
  localparam int unsigned SCREEN_H    = 600;
  localparam int unsigned POS_W       = 12;
  localparam int unsigned VEL_W       = 6;

  typedef enum logic [1:0] {IDLE, FALL, RISE, DONE} bounce_state_t;

endpackage

// File: rtl/rect_bounce_ctl_if.sv
// Frame-tick inputs, mouse position and draw-stage position outputs of the controller.
interface rect_bounce_ctl_if;
  import rect_bounce_ctl_pkg::*;

  logic             vblnk;
  logic             start;
  logic [POS_W-1:0] xpos_in;
  logic [POS_W-1:0] ypos_in;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic             at_rest;

  modport master (
    output vblnk, start, xpos_in, ypos_in,
    input  xpos, ypos, at_rest
  );

  modport slave (
    input  vblnk, start, xpos_in, ypos_in,
    output xpos, ypos, at_rest
  );

endinterface

// File: rtl/rect_bounce_ctl.sv
// Per-frame rectangle position: follows the mouse when idle, otherwise falls,
// bounces with damping and settles on the floor. All updates happen on the
// rising edge of vblnk so the draw stage never sees a mid-frame change.
module rect_bounce_ctl
  import rect_bounce_ctl_pkg::*;
#(
  parameter int unsigned FLOOR_Y    = SCREEN_H - RECT_LENGTH,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned VMAX       = 31,
  parameter int unsigned DAMP_SHIFT = 2,
  parameter int unsigned V_STOP     = 3
) (
  input logic              clk,
  input logic              rst_n,
  rect_bounce_ctl_if.slave bus
);

  localparam logic [POS_W:0]   FLOOR_Y13 = FLOOR_Y[POS_W:0];
  localparam logic [VEL_W-1:0] GRAV_V    = GRAVITY[VEL_W-1:0];
  localparam logic [VEL_W-1:0] VMAX_V    = VMAX[VEL_W-1:0];
  localparam logic [VEL_W-1:0] V_STOP_V  = V_STOP[VEL_W-1:0];

  bounce_state_t    r_state, w_state_n;
  logic [POS_W-1:0] r_xpos, w_xpos_n;
  logic [POS_W-1:0] r_ypos, w_ypos_n;
  logic [VEL_W-1:0] r_vel, w_vel_n;
  logic             r_at_rest, w_at_rest_n;
  logic             r_vblnk_d;
  logic             w_tick;

  // Fall/rise arithmetic carried one bit wider so overflow is caught before clamping
  logic [VEL_W:0]   w_vel_inc;
  logic [VEL_W-1:0] w_fall_vel;
  logic [POS_W:0]   w_fall_y;
  logic [VEL_W-1:0] w_bounce_vel;
  logic [VEL_W-1:0] w_rise_vel;
  logic             w_rise_hits_top;

  assign w_tick = bus.vblnk & ~r_vblnk_d;

  // Frame tick edge detector on vblnk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_d <= 1'b0;
    end else begin
      r_vblnk_d <= bus.vblnk;
    end
  end

  // Motion arithmetic shared by the next-state logic
  always_comb begin
    w_vel_inc       = {1'b0, r_vel} + {1'b0, GRAV_V};
    w_fall_vel      = (w_vel_inc > {1'b0, VMAX_V}) ? VMAX_V : w_vel_inc[VEL_W-1:0];
    w_fall_y        = {1'b0, r_ypos} + {{(POS_W + 1 - VEL_W){1'b0}}, w_fall_vel};
    w_bounce_vel    = w_fall_vel - (w_fall_vel >> DAMP_SHIFT);
    w_rise_vel      = (r_vel > GRAV_V) ? (r_vel - GRAV_V) : '0;
    w_rise_hits_top = !(r_ypos > {{(POS_W - VEL_W){1'b0}}, r_vel});
  end

  // Next state, next position and next velocity for the coming frame tick
  always_comb begin
    w_state_n   = r_state;
    w_xpos_n    = r_xpos;
    w_ypos_n    = r_ypos;
    w_vel_n     = r_vel;
    w_at_rest_n = r_at_rest;
    case (r_state)
      IDLE: begin
        w_xpos_n    = bus.xpos_in;
        w_ypos_n    = ({1'b0, bus.ypos_in} > FLOOR_Y13) ? FLOOR_Y13[POS_W-1:0] : bus.ypos_in;
        w_vel_n     = '0;
        w_at_rest_n = 1'b0;
        if (bus.start) begin
          w_state_n = FALL;
        end
      end
      FALL: begin
        if (w_fall_y < FLOOR_Y13) begin
          w_ypos_n = w_fall_y[POS_W-1:0];
          w_vel_n  = w_fall_vel;
        end else begin
          w_ypos_n = FLOOR_Y13[POS_W-1:0];
          if (w_bounce_vel < V_STOP_V) begin
            w_vel_n     = '0;
            w_state_n   = DONE;
            w_at_rest_n = 1'b1;
          end else begin
            w_vel_n   = w_bounce_vel;
            w_state_n = RISE;
          end
        end
      end
      RISE: begin
        w_ypos_n = w_rise_hits_top ? '0 : (r_ypos - {{(POS_W - VEL_W){1'b0}}, r_vel});
        // Apex reached (or ceiling hit): restart the fall from standstill
        if (w_rise_hits_top || (w_rise_vel == '0)) begin
          w_vel_n   = '0;
          w_state_n = FALL;
        end else begin
          w_vel_n = w_rise_vel;
        end
      end
      DONE: begin
        w_ypos_n    = FLOOR_Y13[POS_W-1:0];
        w_at_rest_n = 1'b1;
        // Releasing start re-arms; holding it keeps the rectangle parked
        if (!bus.start) begin
          w_state_n   = IDLE;
          w_at_rest_n = 1'b0;
        end
      end
      default: begin
        w_state_n   = IDLE;
        w_vel_n     = '0;
        w_at_rest_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs advance only on the frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_xpos    <= '0;
      r_ypos    <= '0;
      r_vel     <= '0;
      r_at_rest <= 1'b0;
    end else if (w_tick) begin
      r_state   <= w_state_n;
      r_xpos    <= w_xpos_n;
      r_ypos    <= w_ypos_n;
      r_vel     <= w_vel_n;
      r_at_rest <= w_at_rest_n;
    end
  end

  assign bus.xpos    = r_xpos;
  assign bus.ypos    = r_ypos;
  assign bus.at_rest = r_at_rest;

endmodule

// File: tb/tb_rect_bounce_ctl.sv
// Scoreboard bench for rect_bounce_ctl: stimulus queues hand-computed positions,
// a monitor process compares them against the DUT on each sample request.
module tb_rect_bounce_ctl;
  import rect_bounce_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rect_bounce_ctl_if bus_a ();
  rect_bounce_ctl_if bus_b ();

  // Default-geometry DUT for the main scenarios
  rect_bounce_ctl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  // Short floor, no damping: the rise overshoots the top so the ceiling clamp is reachable
  rect_bounce_ctl #(
    .FLOOR_Y    (40),
    .DAMP_SHIFT (5)
  ) u_dut_clamp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    string name;
    bit    sel_b;
    int    x;
    int    y;
    bit    rest;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push_exp(input string name, input bit sel_b, input int x, input int y,
                          input bit rest);
    exp_t e;
    e.name  = name;
    e.sel_b = sel_b;
    e.x     = x;
    e.y     = y;
    e.rest  = rest;
    q.push_back(e);
    ->sample_ev;
    @(negedge clk);
  endtask

  task automatic expect_a(input string name, input int x, input int y, input bit rest);
    push_exp(name, 1'b0, x, y, rest);
  endtask

  task automatic expect_b(input string name, input int x, input int y, input bit rest);
    push_exp(name, 1'b1, x, y, rest);
  endtask

  // One shortened frame: 4 clk of vblnk high, 16 clk low
  task automatic frame();
    bus_a.vblnk = 1'b1;
    bus_b.vblnk = 1'b1;
    repeat (4) @(negedge clk);
    bus_a.vblnk = 1'b0;
    bus_b.vblnk = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Monitor: pops one expectation per sample request and compares
  initial begin : monitor
    exp_t e;
    int   ax;
    int   ay;
    bit   ar;
    forever begin
      @(sample_ev);
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL sample_without_expectation: queue empty");
      end else begin
        e = q.pop_front();
        if (e.sel_b) begin
          ax = int'(bus_b.xpos);
          ay = int'(bus_b.ypos);
          ar = bus_b.at_rest;
        end else begin
          ax = int'(bus_a.xpos);
          ay = int'(bus_a.ypos);
          ar = bus_a.at_rest;
        end
        if (ax == e.x && ay == e.y && ar == e.rest) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got x=%0d y=%0d at_rest=%0d, want x=%0d y=%0d at_rest=%0d",
                   e.name, ax, ay, ar, e.x, e.y, e.rest);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int fall_tbl[5];
    fall_tbl = '{1, 3, 6, 10, 15};

    rst_n         = 1'b0;
    bus_a.vblnk   = 1'b0;
    bus_a.start   = 1'b0;
    bus_a.xpos_in = '0;
    bus_a.ypos_in = '0;
    bus_b.vblnk   = 1'b0;
    bus_b.start   = 1'b0;
    bus_b.xpos_in = 12'd5;
    bus_b.ypos_in = '0;
    repeat (3) @(negedge clk);
    expect_a("reset_state", 0, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle tracking with floor clamp on the mouse y
    bus_a.xpos_in = 12'd100;
    bus_a.ypos_in = 12'd700;
    frame();
    expect_a("idle_track_clamp", 100, 536, 1'b0);
    bus_a.xpos_in = 12'd200;
    bus_a.ypos_in = 12'd50;
    repeat (20) @(negedge clk);
    expect_a("idle_no_tick_hold", 100, 536, 1'b0);

    // vblnk held high across several frames: exactly one update
    bus_a.vblnk = 1'b1;
    bus_b.vblnk = 1'b1;
    repeat (60) @(negedge clk);
    expect_a("vblnk_held_one_update", 200, 50, 1'b0);
    bus_a.xpos_in = 12'd300;
    bus_a.ypos_in = 12'd60;
    repeat (20) @(negedge clk);
    expect_a("vblnk_held_no_more", 200, 50, 1'b0);
    bus_a.vblnk = 1'b0;
    bus_b.vblnk = 1'b0;
    repeat (16) @(negedge clk);

    // start mid-frame has no effect until the next tick
    bus_a.xpos_in = 12'd10;
    bus_a.ypos_in = 12'd0;
    bus_a.start   = 1'b1;
    repeat (10) @(negedge clk);
    expect_a("start_without_tick", 200, 50, 1'b0);
    frame();
    expect_a("start_loads_mouse", 10, 0, 1'b0);
    bus_a.start   = 1'b0;
    bus_a.xpos_in = 12'd999;

    // Free fall from the top: triangular numbers, then velocity saturation
    for (int i = 0; i < 5; i++) begin
      frame();
      expect_a($sformatf("fall_tick%0d", i + 1), 10, fall_tbl[i], 1'b0);
    end
    frames(26);
    expect_a("fall_tick31", 10, 496, 1'b0);
    frame();
    expect_a("vel_saturates_vmax", 10, 527, 1'b0);
    frame();
    expect_a("impact_vel31", 10, 536, 1'b0);
    frame();
    expect_a("rise_vel24", 10, 512, 1'b0);
    frame();
    expect_a("rise_vel23", 10, 489, 1'b0);
    frames(22);
    expect_a("rise_apex", 10, 236, 1'b0);
    frame();
    expect_a("refall_from_apex", 10, 237, 1'b0);

    // Asynchronous reset mid-fall, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    expect_a("reset_mid_fall", 0, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bounce with impact velocity 16
    bus_a.xpos_in = 12'd50;
    bus_a.ypos_in = 12'd400;
    bus_a.start   = 1'b1;
    frame();
    expect_a("load_400", 50, 400, 1'b0);
    bus_a.start = 1'b0;
    frame();
    expect_a("no_residual_velocity", 50, 401, 1'b0);
    frames(14);
    expect_a("fall_to_520", 50, 520, 1'b0);
    frame();
    expect_a("impact_vel16", 50, 536, 1'b0);
    frame();
    expect_a("rise_524", 50, 524, 1'b0);
    frame();
    expect_a("rise_513", 50, 513, 1'b0);
    bus_a.start   = 1'b1;
    bus_a.xpos_in = 12'd777;
    frame();
    expect_a("rise_503_start_ignored", 50, 503, 1'b0);
    frames(9);
    expect_a("rise_vel0_to_fall", 50, 458, 1'b0);
    frame();
    expect_a("fall_after_rise", 50, 459, 1'b0);

    // Short drop lands with damped velocity below V_STOP: rest
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_a.xpos_in = 12'd70;
    bus_a.ypos_in = 12'd533;
    frame();
    expect_a("load_533", 70, 533, 1'b0);
    frame();
    expect_a("fall_534", 70, 534, 1'b0);
    frame();
    expect_a("rest_done", 70, 536, 1'b1);
    frame();
    expect_a("rest_start_held", 70, 536, 1'b1);
    bus_a.start   = 1'b0;
    bus_a.xpos_in = 12'd80;
    bus_a.ypos_in = 12'd100;
    frame();
    expect_a("done_to_idle", 70, 536, 1'b0);
    frame();
    expect_a("idle_rearmed", 80, 100, 1'b0);

    // Ceiling clamp on the short-floor instance
    bus_b.start = 1'b1;
    frame();
    expect_b("b_load_top", 5, 0, 1'b0);
    bus_b.start = 1'b0;
    frames(8);
    expect_b("b_fall_36", 5, 36, 1'b0);
    frame();
    expect_b("b_floor_hit", 5, 40, 1'b0);
    frames(6);
    expect_b("b_rise_1", 5, 1, 1'b0);
    frame();
    expect_b("b_ceiling_clamp", 5, 0, 1'b0);
    frame();
    expect_b("b_fall_after_clamp", 5, 1, 1'b0);

    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drained: got %0d pending, want 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
